// File: rtl/mux_arb4.sv
// ---------------------------------------------------------------------------
// mux_arb4 -- round-robin arbiter for a shared 4:1 mux path with burst limit.
//
// Each requester holds its req bit while it wants the path. When idle, the
// arbiter picks the first requester at or after (last+1) mod 4. It then holds
// the grant until either MAX_BURST beats have transferred or the granted
// requester drops its request. Every release is followed by one idle cycle
// before the next grant.
//
// Ports:
//   clk      : clock; all state changes on the rising edge
//   rst      : synchronous active-high reset
//   req      : per-requester request bits
//   ready    : downstream accepts the current beat
//   sel      : registered mux select (index of the granted requester)
//   gnt      : registered one-hot grant, zero when idle
//   valid    : a beat from the granted requester is presented (combinational)
//   beat_cnt : beats accepted so far in the current grant
//   done     : one-cycle pulse in the cycle after a grant is released
// ---------------------------------------------------------------------------
module mux_arb4 #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       valid,
  output logic [7:0] beat_cnt,
  output logic       done
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t     state;
  logic [1:0] last;
  logic [1:0] winner;
  logic [1:0] scan_idx;
  logic       xfer;
  logic       release_grant;

  // Round-robin pick: scan offsets 4..1 from last so that the smallest
  // offset (closest after last) overwrites earlier candidates and wins.
  // Offset 4 wraps to last itself, giving it the lowest priority.
  always_comb begin
    winner   = last + 2'd1;
    scan_idx = last;
    for (int k = 4; k >= 1; k--) begin
      scan_idx = last + 2'(k);
      if (req[scan_idx]) begin
        winner = scan_idx;
      end
    end
  end

  assign valid = (state == GRANT) && req[sel];
  assign xfer  = valid && ready;

  // Release on the final beat of a burst, or as soon as the owner lets go.
  assign release_grant = (state == GRANT) &&
                         (!req[sel] || (xfer && (beat_cnt == LAST_BEAT)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      beat_cnt <= 8'd0;
      done     <= 1'b0;
      last     <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (req != 4'b0000) begin
            state    <= GRANT;
            gnt      <= 4'b0001 << winner;
            sel      <= winner;
            last     <= winner;
            beat_cnt <= 8'd0;
          end
        end
        GRANT: begin
          if (release_grant) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            beat_cnt <= 8'd0;
            done     <= 1'b1;
          end else begin
            done <= 1'b0;
            if (xfer) begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arb4.sv
// ---------------------------------------------------------------------------
// tb_mux_arb4 -- scoreboard bench for mux_arb4.
// Two instances share the same stimulus: one with MAX_BURST=4, one with
// MAX_BURST=1. A stimulus process drives req/ready/rst once per cycle,
// evaluates a behavioural model per instance and queues the expected outputs
// for that cycle; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_mux_arb4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ready;

  logic [1:0] sel_a, sel_b;
  logic [3:0] gnt_a, gnt_b;
  logic       valid_a, valid_b;
  logic [7:0] bc_a, bc_b;
  logic       done_a, done_b;

  mux_arb4 #(.MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .sel(sel_a), .gnt(gnt_a), .valid(valid_a), .beat_cnt(bc_a), .done(done_a)
  );

  mux_arb4 #(.MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .sel(sel_b), .gnt(gnt_b), .valid(valid_b), .beat_cnt(bc_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [7:0] bc;
    logic       done;
    logic       valid;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int total = 0;
  int bad   = 0;

  // Behavioural model state per instance: owner is the granted requester,
  // or -1 when nobody holds the path.
  int owner[2];
  int beats[2];
  int last_w[2];
  int cur_sel[2];
  bit pend_done[2];
  int burst[2] = '{4, 1};

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      owner[d]     = -1;
      beats[d]     = 0;
      last_w[d]    = 3;
      cur_sel[d]   = 0;
      pend_done[d] = 0;
    end
  endtask

  // Drive one cycle of inputs, record what each instance must show during
  // this cycle, then advance the model to the state after the next edge.
  task automatic step(input bit r, input logic [3:0] rq, input bit rd);
    exp_t e;
    bit   has_beat;
    rst   = r;
    req   = rq;
    ready = rd;
    for (int d = 0; d < 2; d++) begin
      e.gnt   = (owner[d] >= 0) ? 4'(1 << owner[d]) : 4'b0000;
      e.sel   = 2'(cur_sel[d]);
      e.bc    = 8'(beats[d]);
      e.done  = pend_done[d];
      e.valid = (owner[d] >= 0) && rq[cur_sel[d]];
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);

      if (r) begin
        owner[d] = -1; beats[d] = 0; last_w[d] = 3; cur_sel[d] = 0; pend_done[d] = 0;
      end else if (owner[d] < 0) begin
        pend_done[d] = 0;
        for (int k = 1; k <= 4; k++) begin
          if (owner[d] < 0 && rq[(last_w[d] + k) % 4]) begin
            owner[d]   = (last_w[d] + k) % 4;
            cur_sel[d] = owner[d];
            last_w[d]  = owner[d];
            beats[d]   = 0;
          end
        end
      end else begin
        has_beat = rq[owner[d]] && rd;
        if (!rq[owner[d]] || (has_beat && beats[d] + 1 == burst[d])) begin
          owner[d] = -1; beats[d] = 0; pend_done[d] = 1;
        end else begin
          pend_done[d] = 0;
          if (has_beat) beats[d] = beats[d] + 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_one(input string name, input exp_t e,
                           input logic [3:0] g, input logic [1:0] s,
                           input logic [7:0] b, input logic dn, input logic v);
    total++;
    if (g !== e.gnt || s !== e.sel || b !== e.bc || dn !== e.done || v !== e.valid) begin
      bad++;
      $display("FAIL %s t=%0t got gnt=%b sel=%0d cnt=%0d done=%b valid=%b want gnt=%b sel=%0d cnt=%0d done=%b valid=%b",
               name, $time, g, s, b, dn, v, e.gnt, e.sel, e.bc, e.done, e.valid);
    end
  endtask

  // Monitor: compares whatever each DUT presents against the queued cycle.
  always @(negedge clk) begin
    exp_t ea;
    exp_t eb;
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      check_one("burst4", ea, gnt_a, sel_a, bc_a, done_a, valid_a);
      if (done_a) $display("release burst4 sel=%0d t=%0t", sel_a, $time);
    end
    if (q_b.size() > 0) begin
      eb = q_b.pop_front();
      check_one("burst1", eb, gnt_b, sel_b, bc_b, done_b, valid_b);
      if (done_b) $display("release burst1 sel=%0d t=%0t", sel_b, $time);
    end
  end

  initial begin
    logic [3:0] rq;
    rst   = 1'b1;
    req   = 4'b0000;
    ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset held with requests pending: valid must stay low.
    step(1, 4'b1111, 1);
    step(1, 4'b1111, 1);

    // All four requesting with ready high: round-robin 0,1,2,3,0.
    for (int i = 0; i < 30; i++) step(0, 4'b1111, 1);

    // Requester 2 drops after two accepted beats.
    step(1, 4'b0000, 1);
    for (int i = 0; i < 3; i++) step(0, 4'b0100, 1);
    for (int i = 0; i < 3; i++) step(0, 4'b0000, 1);

    // Grant to 1 stalled by ready low, then released after its burst.
    step(1, 4'b0000, 0);
    step(0, 4'b0001, 1);
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 1);
    for (int i = 0; i < 11; i++) step(0, 4'b0010, 0);
    for (int i = 0; i < 6; i++) step(0, 4'b0010, 1);

    // After serving 1, 0 and 1 both request: wrap-around picks 0.
    for (int i = 0; i < 6; i++) step(0, 4'b0011, 1);

    // Reset mid-burst on requester 3, then 0 and 3 request.
    step(1, 4'b0000, 1);
    step(0, 4'b0000, 1);
    for (int i = 0; i < 3; i++) step(0, 4'b1000, 1);
    step(1, 4'b1000, 1);
    for (int i = 0; i < 8; i++) step(0, 4'b1001, 1);

    // Single requester held: repeated short grants with a bubble each time.
    for (int i = 0; i < 12; i++) step(0, 4'b0001, 1);

    // Randomized traffic with occasional resets and ready stalls.
    rq = 4'($urandom);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      step(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    #1;
    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d/%0d want 0/0", q_a.size(), q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
